ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- INHIBIT_CYCLES, 5000, clk cycles ps2Clk is held low to request-to-send (100 us at 50 MHz)
- START_TIMEOUT, 750000, max clk cycles from clock release to first device falling edge (15 ms)
- XFER_TIMEOUT, 100000, max clk cycles from first falling edge to acknowledge (2 ms)
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk  input  1  system clock, 50 MHz
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- ps2Clk  input  1  PS/2 clock line as read from the pad
- ps2Data  input  1  PS/2 data line as read from the pad
- ps2ClkLow  output  1  1 = drive ps2Clk pad low, 0 = release (open-drain)
- ps2DataLow  output  1  1 = drive ps2Data pad low, 0 = release (open-drain)
- start  input  1  1-cycle request to send txData
- txData  input  8  command byte, e.g. 8'hED set LEDs, 8'hFF reset
- busy  output  1  transfer in progress; start is ignored while busy
- done  output  1  1-cycle pulse: transfer ended with device ack
- error  output  1  1-cycle pulse: transfer aborted (timeout or missing ack)

Function
REQ-003 ps2Clk and ps2Data SHALL pass through 2-FF synchronizers; a falling edge is detected when the previous synchronized clock is 1 and the current one is 0.
REQ-004 The FSM SHALL have states IDLE, INHIBIT, RTS, SEND, ACK, RELEASE.
REQ-005 IDLE: both lines released, busy=0; start=1 latches txData and its odd parity bit (~^txData) and enters INHIBIT on the next edge.
REQ-006 INHIBIT: ps2ClkLow=1 for exactly INHIBIT_CYCLES clk cycles; ps2DataLow is asserted during the last cycle of INHIBIT.
REQ-007 RTS: ps2ClkLow=0, ps2DataLow=1 (start bit); first falling edge enters SEND; no edge within START_TIMEOUT cycles -> error.
REQ-008 SEND: on each falling edge, a 4-bit counter selects the next bit: edges 1-8 drive txData[0..7] LSB first, edge 9 drives parity, edge 10 releases data (stop bit); ps2DataLow = ~bit.
REQ-009 ACK: the bit value is sampled from synchronized ps2Data at falling edge 11; 0 = ack -> RELEASE; 1 -> error.
REQ-010 RELEASE: both lines released; waits until synchronized ps2Clk and ps2Data are both 1, then pulses done and returns to IDLE.
REQ-011 XFER_TIMEOUT SHALL count from entry into SEND until ACK completes; expiry -> error.
REQ-012 On error: pulse error for 1 cycle, release both lines in that same cycle, return to IDLE; done SHALL NOT pulse.
REQ-013 busy SHALL be 1 in every state except IDLE; done and error SHALL never be 1 in the same cycle.
REQ-014 start while busy=1 SHALL have no effect; txData is read only in IDLE.
REQ-015 Timeout counters SHALL be wide enough for their parameter ($clog2) and SHALL saturate rather than wrap.

Reset
REQ-016 rst=0 SHALL asynchronously force IDLE, ps2ClkLow=0, ps2DataLow=0, busy=0, done=0, error=0, clear all counters, and clear the synchronizers to 1.
REQ-017 Reset mid-transfer SHALL release both lines immediately, with no done/error pulse; the first start after reset is accepted normally.

Verification
REQ-018 txData=8'hED, device model clocks at 12.5 kHz and acks -> data bits 1,0,1,1,0,1,1,1, parity 1, stop released, done pulse, busy falls.
REQ-019 txData=8'h01 -> parity 0 driven at edge 9; txData=8'h00 -> parity 1.
REQ-020 Device never clocks -> error pulse exactly START_TIMEOUT cycles after RTS entry, lines released, no done.
REQ-021 Device holds data high at edge 11 -> error pulse, no done.
REQ-022 start pulsed again mid-SEND with txData=8'hFF -> ignored; original byte completes unchanged.
REQ-023 rst=0 asserted at edge 5 of a transfer -> ps2ClkLow=ps2DataLow=0 within the same cycle, busy=0, no pulses.

Source files
------------

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : PS/2 host-to-device transmitter. The host requests to send by
//             holding the clock line low, then places a start bit on the data
//             line. It shifts out eight data bits (LSB first), an odd parity
//             bit and a stop bit on the device's falling clock edges. Finally
//             it checks the device acknowledge bit.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         system clock (50 MHz nominal)
//    rst         asynchronous reset, active low
//    ps2Clk      PS/2 clock line as read from the pad
//    ps2Data     PS/2 data line as read from the pad
//    ps2ClkLow   1 = pull ps2Clk pad low, 0 = release (open drain)
//    ps2DataLow  1 = pull ps2Data pad low, 0 = release (open drain)
//    start       one-cycle request to send txData (ignored while busy)
//    txData      command byte to send
//    busy        transfer in progress
//    done        one-cycle pulse: transfer acknowledged by the device
//    error       one-cycle pulse: transfer aborted (timeout or missing ack)
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic       ps2ClkLow,
    output logic       ps2DataLow,
    input  logic       start,
    input  logic [7:0] txData,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int ST_W  = $clog2(START_TIMEOUT + 1);
    localparam int XF_W  = $clog2(XFER_TIMEOUT + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(START_TIMEOUT - 1);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(START_TIMEOUT);
    localparam logic [XF_W-1:0]  XF_LAST  = XF_W'(XFER_TIMEOUT - 1);
    localparam logic [XF_W-1:0]  XF_MAX   = XF_W'(XFER_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        RTS     = 3'd2,
        SEND    = 3'd3,
        ACK     = 3'd4,
        RELEASE = 3'd5
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Pad synchronizers. They reset to 1 (idle bus level) so that no
    // spurious falling edge appears right after reset.
    // ------------------------------------------------------------------
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       clk_s;
    logic       data_s;
    logic       fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2Clk};
            data_sync <= {data_sync[0], ps2Data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall   = clk_prev & ~clk_s;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [7:0]       tx_byte;
    logic             tx_par;
    logic [INH_W-1:0] inh_cnt;
    logic [ST_W-1:0]  start_tmr;
    logic [XF_W-1:0]  xfer_tmr;
    logic [3:0]       bit_cnt;     // device falling edges seen so far
    logic             send_bit;
    logic             do_done;
    logic             do_error;

    // The bit on the wire after falling edge N: data for 1..8,
    // parity for 9. The stop bit (edge 10) is a released line and
    // is handled by the ACK state.
    always_comb begin
        send_bit = 1'b1;
        if (bit_cnt >= 4'd1 && bit_cnt <= 4'd8) begin
            send_bit = tx_byte[bit_cnt[2:0] - 3'd1];
        end else if (bit_cnt == 4'd9) begin
            send_bit = tx_par;
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and line drive
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        ps2ClkLow  = 1'b0;
        ps2DataLow = 1'b0;
        do_done    = 1'b0;
        do_error   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = INHIBIT;
                end
            end

            INHIBIT: begin
                ps2ClkLow = 1'b1;
                // Pull data low in the final inhibit cycle so that the
                // start bit is already on the wire when the clock is released.
                if (inh_cnt == INH_LAST) begin
                    ps2DataLow = 1'b1;
                    state_next = RTS;
                end
            end

            RTS: begin
                ps2DataLow = 1'b1;
                if (fall) begin
                    state_next = SEND;
                end else if (start_tmr >= ST_LAST) begin
                    do_error   = 1'b1;
                    state_next = IDLE;
                end
            end

            SEND: begin
                ps2DataLow = ~send_bit;
                if (fall) begin
                    if (bit_cnt == 4'd9) begin
                        state_next = ACK;
                    end
                end else if (xfer_tmr >= XF_LAST) begin
                    do_error   = 1'b1;
                    state_next = IDLE;
                end
            end

            ACK: begin
                // Data is released (stop bit). The device pulls it low before
                // falling edge 11 to acknowledge.
                if (fall) begin
                    if (!data_s) begin
                        state_next = RELEASE;
                    end else begin
                        do_error   = 1'b1;
                        state_next = IDLE;
                    end
                end else if (xfer_tmr >= XF_LAST) begin
                    do_error   = 1'b1;
                    state_next = IDLE;
                end
            end

            RELEASE: begin
                if (clk_s && data_s) begin
                    do_done    = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Counters, byte latch and result pulses. The pulses are registered,
    // so they coincide with the first IDLE cycle, where both lines are
    // already released.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_byte   <= 8'h00;
            tx_par    <= 1'b0;
            inh_cnt   <= '0;
            start_tmr <= '0;
            xfer_tmr  <= '0;
            bit_cnt   <= 4'd0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done  <= do_done;
            error <= do_error;

            if (state == IDLE && start) begin
                tx_byte <= txData;
                tx_par  <= ~^txData;
            end

            if (state == INHIBIT) begin
                inh_cnt <= inh_cnt + INH_W'(1);
            end else begin
                inh_cnt <= '0;
            end

            if (state == RTS) begin
                if (start_tmr < ST_MAX) begin
                    start_tmr <= start_tmr + ST_W'(1);
                end
            end else begin
                start_tmr <= '0;
            end

            if (state == SEND || state == ACK) begin
                if (xfer_tmr < XF_MAX) begin
                    xfer_tmr <= xfer_tmr + XF_W'(1);
                end
            end else begin
                xfer_tmr <= '0;
            end

            if (state == IDLE || state == INHIBIT) begin
                bit_cnt <= 4'd0;
            end else if (fall && (state == RTS || state == SEND || state == ACK)) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ps2_host_tx
//  Purpose  : Self-checking bench for ps2_host_tx. A behavioural PS/2 device
//             clocks the frame in and optionally acknowledges. Expected
//             frames and outcomes are queued when each transfer is issued and
//             compared by an independent monitor when done/error pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH       = 20;
    localparam int STO       = 300;
    localparam int XTO       = 2000;
    localparam int HALF      = 30;
    localparam int START_DLY = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2Clk;
    logic       ps2Data;
    logic       ps2ClkLow;
    logic       ps2DataLow;
    logic       busy;
    logic       done;
    logic       error;

    // Open-drain bus: high unless either side pulls low
    assign ps2Clk  = ~(ps2ClkLow | dev_clk_low);
    assign ps2Data = ~(ps2DataLow | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (STO),
        .XFER_TIMEOUT   (XTO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2Clk     (ps2Clk),
        .ps2Data    (ps2Data),
        .ps2ClkLow  (ps2ClkLow),
        .ps2DataLow (ps2DataLow),
        .start      (start),
        .txData     (txData),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    typedef struct packed {
        logic [9:0] frame;      // {stop, parity, data[7:0]}
        logic       exp_done;
        logic       chk_frame;
        logic       chk_time;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         failures = 0;
    logic [9:0] cap_frame = '0;
    int         cyc = 0;
    int         inh_len = 0;
    int         inh_data = 0;
    int         rts_cyc = 0;
    logic       prev_clk_low = 1'b0;
    logic       prev_data_low = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: inhibit timing and scoreboard on done/error pulses
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        cyc++;
        if (ps2ClkLow) begin
            inh_len++;
            if (ps2DataLow) inh_data++;
        end else if (prev_clk_low) begin
            check("inhibit_cycles", 32'(inh_len), 32'(INH));
            check("inhibit_data_low_cycles", 32'(inh_data), 32'd1);
            check("inhibit_data_low_last", 32'(prev_data_low), 32'd1);
            rts_cyc  = cyc;
            inh_len  = 0;
            inh_data = 0;
        end
        prev_clk_low  = ps2ClkLow;
        prev_data_low = ps2DataLow;

        if (done || error) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({done, error}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_error_exclusive", 32'(done & error), 32'd0);
                check("outcome_done", 32'(done), 32'(mon_e.exp_done));
                check("outcome_error", 32'(error), 32'(!mon_e.exp_done));
                check("lines_released", 32'({ps2ClkLow, ps2DataLow}), 32'd0);
                check("busy_at_end", 32'(busy), 32'd0);
                if (mon_e.chk_frame) check("frame", 32'(cap_frame), 32'(mon_e.frame));
                if (mon_e.chk_time)  check("start_timeout_cycles", 32'(cyc - rts_cyc), 32'(STO));
            end
        end
    end

    // ------------------------------------------------------------------
    // Device model
    // ------------------------------------------------------------------
    task automatic run_device(input bit clocks, input bit ack, input int abort_at, input int inject_at);
        int n;
        n = 0;
        while (!ps2ClkLow && n < 100) begin @(negedge clk); n++; end
        if (!ps2ClkLow) begin
            check("inhibit_started", 32'(ps2ClkLow), 32'd1);
            return;
        end
        n = 0;
        while (ps2ClkLow && n < INH + 50) begin @(negedge clk); n++; end
        if (ps2ClkLow) begin
            check("inhibit_ended", 32'(ps2ClkLow), 32'd0);
            return;
        end
        if (!clocks) return;
        repeat (START_DLY) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) begin
                dev_data_low = 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            if (k == abort_at) begin
                #1 rst = 1'b0;
                #1;
                check("abort_clk_low", 32'(ps2ClkLow), 32'd0);
                check("abort_data_low", 32'(ps2DataLow), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_pulses", 32'({done, error}), 32'd0);
                dev_clk_low = 1'b0;
                return;
            end
            if (k == inject_at) begin
                @(negedge clk);
                start  = 1'b1;
                txData = 8'hFF;
                @(negedge clk);
                start  = 1'b0;
                repeat (HALF - 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (k <= 10) cap_frame[k-1] = ps2Data;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k == 11) dev_data_low = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // One transfer: queue expectation, pulse start, run device, wait
    // ------------------------------------------------------------------
    task automatic send(input logic [7:0] b, input logic [9:0] frame, input bit exp_done,
                        input bit chk_frame, input bit chk_time, input bit clocks,
                        input bit ack, input int abort_at, input int inject_at);
        exp_t e;
        int   n;
        cap_frame = '0;
        if (abort_at == 0) begin
            e.frame     = frame;
            e.exp_done  = exp_done;
            e.chk_frame = chk_frame;
            e.chk_time  = chk_time;
            exp_q.push_back(e);
        end
        @(negedge clk);
        txData = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        txData = 8'hFF;     // must not affect the latched byte
        run_device(clocks, ack, abort_at, inject_at);
        n = 0;
        while (exp_q.size() != 0 && n < STO + XTO + 500) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            check("response_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_clk_low", 32'(ps2ClkLow), 32'd0);
        check("reset_data_low", 32'(ps2DataLow), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        //   byte   frame {stop,par,data}  done chkF chkT clk ack abort inject
        send(8'hED, 10'h3ED, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        send(8'h01, 10'h201, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        send(8'h00, 10'h300, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        send(8'h5A, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);   // device silent
        send(8'hA5, 10'h3A5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);   // no ack
        send(8'h3C, 10'h33C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 3);   // start mid-SEND
        send(8'h55, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5, 0);   // reset at edge 5
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        send(8'h80, 10'h280, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
